// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between a requester and the bit-serial adder.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, cin, a, b,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, sub, cin, a, b,
                  output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub controller: one full-adder cell (two half adders)
// stepped LSB-first over WIDTH bits, result published with a done pulse.

module serial_add_ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic h1, c1, s, c2, carry_nx, cmsb, last;

  // shared full-adder cell: operand LSBs plus the running carry
  serial_add_ha u_ha1 (.x_i(opa_q[0]), .y_i(opb_q[0]), .s_o(h1), .c_o(c1));
  serial_add_ha u_ha2 (.x_i(h1),       .y_i(carry_q),  .s_o(s),  .c_o(c2));

  assign carry_nx = c1 | c2;
  assign cmsb     = carry_q;               // carry into the bit being processed
  assign last     = (cnt_q == CW'(WIDTH - 1));

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state, datapath next values and status outputs
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;     // subtract = a + ~b + 1
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        opa_d    = {1'b0, opa_q[WIDTH-1:1]};
        opb_d    = {1'b0, opb_q[WIDTH-1:1]};
        res_d    = {s, res_q[WIDTH-1:1]};
        carry_d  = carry_nx;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          // publish only the completed word; outputs never see partials
          sum_d   = {s, res_q[WIDTH-1:1]};
          cout_d  = carry_nx;
          ovf_d   = cmsb ^ carry_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and held-start random checks of serial_add_ctrl at WIDTH 8, 2, 16.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  b8 ();
  serial_add_ctrl_if #(.WIDTH(2))  b2 ();
  serial_add_ctrl_if #(.WIDTH(16)) b16 ();

  serial_add_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  serial_add_ctrl #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(b2));
  serial_add_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: {ovf, cout, sum} from whole-word arithmetic
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [32:0] mask, bb, full, low;
    logic        c, cmsb;
    mask = (33'd1 << w) - 33'd1;
    bb   = sb ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
    c    = sb ? 1'b1 : ci;
    full = ({1'b0, a} & mask) + bb + {32'd0, c};
    low  = ({1'b0, a} & (mask >> 1)) + (bb & (mask >> 1)) + {32'd0, c};
    cmsb = low[w-1];
    return {cmsb ^ full[w], full[w], full[31:0] & mask[31:0]};
  endfunction

  // one start pulse on the WIDTH=8 instance, then timing and result checks
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb,
                     input logic [7:0] es, input logic ec, input logic eo);
    int lat = 0, nb = 0;
    bit seen = 0;
    logic [9:0] pre;
    pre = {b8.ovf, b8.cout, b8.sum};
    @(negedge clk);
    b8.start = 1'b1; b8.a = a; b8.b = b; b8.cin = ci; b8.sub = sb;
    @(negedge clk);
    b8.start = 1'b0; b8.a = ~a; b8.b = ~b; b8.cin = ~ci; b8.sub = ~sb;
    while (!seen && lat < 20) begin
      if (b8.busy) nb++;
      if (lat == 4) chk({tag, "_hold_mid_run"}, {54'd0, b8.ovf, b8.cout, b8.sum}, {54'd0, pre});
      if (b8.done) seen = 1;
      else begin @(negedge clk); lat++; end
    end
    // done appears in the cycle after edge E0+WIDTH
    chk({tag, "_done_lat"}, 64'(lat), 64'd8);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd8);
    chk({tag, "_result"}, {54'd0, b8.ovf, b8.cout, b8.sum}, {54'd0, eo, ec, es});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {62'd0, b8.done, b8.busy}, 64'd0);
  endtask

  initial begin
    int ndone;
    int n8, n2, n16, l8, l2, l16;
    logic [31:0] a8, bv8, a2, bv2, a16, bv16;
    logic ci8, sb8, ci2, sb2, ci16, sb16;

    b8.start = 0;  b8.a = 0;  b8.b = 0;  b8.cin = 0;  b8.sub = 0;
    b2.start = 0;  b2.a = 0;  b2.b = 0;  b2.cin = 0;  b2.sub = 0;
    b16.start = 0; b16.a = 0; b16.b = 0; b16.cin = 0; b16.sub = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_w8", {53'd0, b8.busy, b8.done, b8.ovf, b8.cout, b8.sum}, 64'd0);
    chk("reset_w2", {57'd0, b2.busy, b2.done, b2.ovf, b2.cout, b2.sum}, 64'd0);
    chk("reset_w16", {45'd0, b16.busy, b16.done, b16.ovf, b16.cout, b16.sum}, 64'd0);
    rst = 1'b0;

    // directed arithmetic
    op8("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op8("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // start during RUN and during DONE must be ignored
    @(negedge clk);
    b8.start = 1; b8.a = 8'h01; b8.b = 8'h01; b8.cin = 0; b8.sub = 0;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      b8.start = (n == 2) || (b8.done === 1'b1);
      b8.a = 8'hAA; b8.b = 8'h55;
      if (b8.done) ndone++;
      if (n == 8) chk("ignore_sum", 64'(b8.sum), 64'h02);
      if (n == 20) chk("ignore_idle", {62'd0, b8.busy, b8.done}, 64'd0);
    end
    b8.start = 0;
    chk("ignore_done_count", 64'(ndone), 64'd1);

    // reset mid-RUN aborts with no done
    @(negedge clk);
    b8.start = 1; b8.a = 8'hFF; b8.b = 8'hFF; b8.cin = 0; b8.sub = 0;
    @(negedge clk);
    b8.start = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {53'd0, b8.busy, b8.done, b8.ovf, b8.cout, b8.sum}, 64'd0);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (b8.done || b8.busy) ndone++;
    end
    chk("abort_no_activity", 64'(ndone), 64'd0);
    op8("after_abort", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);

    // start held high with random operands on all three widths
    a8  = $urandom; bv8  = $urandom; ci8  = 1'($urandom); sb8  = 1'($urandom);
    a2  = $urandom; bv2  = $urandom; ci2  = 1'($urandom); sb2  = 1'($urandom);
    a16 = $urandom; bv16 = $urandom; ci16 = 1'($urandom); sb16 = 1'($urandom);
    @(negedge clk);
    b8.a = a8[7:0];    b8.b = bv8[7:0];    b8.cin = ci8;   b8.sub = sb8;
    b2.a = a2[1:0];    b2.b = bv2[1:0];    b2.cin = ci2;   b2.sub = sb2;
    b16.a = a16[15:0]; b16.b = bv16[15:0]; b16.cin = ci16; b16.sub = sb16;
    b8.start = 1; b2.start = 1; b16.start = 1;
    n8 = 0; n2 = 0; n16 = 0; l8 = -1; l2 = -1; l16 = -1;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (b8.done) begin
        chk("rand_w8", {30'd0, b8.ovf, b8.cout, 24'd0, b8.sum},
            {30'd0, model(8, {24'd0, a8[7:0]}, {24'd0, bv8[7:0]}, ci8, sb8)});
        if (l8 >= 0) chk("interval_w8", 64'(cyc - l8), 64'd10);
        l8 = cyc; n8++;
        a8 = $urandom; bv8 = $urandom; ci8 = 1'($urandom); sb8 = 1'($urandom);
        b8.a = a8[7:0]; b8.b = bv8[7:0]; b8.cin = ci8; b8.sub = sb8;
      end
      if (b2.done) begin
        chk("rand_w2", {30'd0, b2.ovf, b2.cout, 30'd0, b2.sum},
            {30'd0, model(2, {30'd0, a2[1:0]}, {30'd0, bv2[1:0]}, ci2, sb2)});
        if (l2 >= 0) chk("interval_w2", 64'(cyc - l2), 64'd4);
        l2 = cyc; n2++;
        a2 = $urandom; bv2 = $urandom; ci2 = 1'($urandom); sb2 = 1'($urandom);
        b2.a = a2[1:0]; b2.b = bv2[1:0]; b2.cin = ci2; b2.sub = sb2;
      end
      if (b16.done) begin
        chk("rand_w16", {30'd0, b16.ovf, b16.cout, 16'd0, b16.sum},
            {30'd0, model(16, {16'd0, a16[15:0]}, {16'd0, bv16[15:0]}, ci16, sb16)});
        if (l16 >= 0) chk("interval_w16", 64'(cyc - l16), 64'd18);
        l16 = cyc; n16++;
        a16 = $urandom; bv16 = $urandom; ci16 = 1'($urandom); sb16 = 1'($urandom);
        b16.a = a16[15:0]; b16.b = bv16[15:0]; b16.cin = ci16; b16.sub = sb16;
      end
    end
    b8.start = 0; b2.start = 0; b16.start = 0;
    chk("rand_count_w8", 64'(n8 >= 240), 64'd1);
    chk("rand_count_w2", 64'(n2 >= 600), 64'd1);
    chk("rand_count_w16", 64'(n16 >= 130), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
